stim_gen: RTL and testbench
===========================

# stim_gen

- Upstream stimulus generator for the cocotb quickstart design; its output stream feeds the design under test.
- On a start request it emits a programmable number of data words over a valid/ready handshake, then pulses done.
- The word sequence is an incrementing count by default; an LFSR sequence can be compiled in.
- Runs on the same single clock as its consumer, so cocotb benches can drive long, deterministic sequences with one write.

## Interface
Parameters:
- WIDTH, 8, data word width.
- LEN_W, 8, width of len and count.
- TAPS, 8'hB8, Galois LFSR feedback mask (WIDTH bits); used only when the LFSR is compiled in.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a sequence; sampled only in IDLE.
- len  in  LEN_W  number of words to emit; latched on start.
- seed  in  WIDTH  first data word; latched on start.
- out_data  out  WIDTH  current word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at sequence end.
- count  out  LEN_W  words transferred in the current or last sequence.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - busy=0, out_valid=0.
  - start=1 and len!=0 → latch len and seed, clear count, go to RUN.
  - start=1 and len==0 → clear count, go to DONE. No word is emitted.
- RUN:
  - out_valid=1, busy=1.
  - A handshake is out_valid & out_ready. On a handshake: count increments and out_data advances to the next pattern value.
  - If count+1 == latched len on a handshake, go to DONE and deassert out_valid on the same edge.
  - start is ignored.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Pattern, default: next = out_data + 1 mod 2^WIDTH; 0xFF wraps to 0x00.
- count holds its final value after done until the next accepted start. count never exceeds len.
- len, seed and start changing outside IDLE have no effect.
- Reset in any state, including mid-RUN: go to IDLE immediately, with all outputs 0. No done pulse is produced for the aborted sequence.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, done=0, count=0.
- Reset asserts asynchronously and is released synchronously to clk by the integrating level.
- Latency: start sampled at edge N → out_valid=1 with out_data=seed after edge N.
- Throughput: one word per cycle while out_ready is held high. len words take len cycles.
- done rises at the edge following the final handshake and falls one edge later. The earliest next start is sampled at the edge where done falls, since the state is then IDLE.
- With len==0, done is high for the cycle after edge N.
- Backpressure: while out_valid=1 and out_ready=0, out_data and count are held stable.
- out_valid never depends combinationally on out_ready.

## Configuration
- Macro: STIM_GEN_LFSR_EN.
- Defined:
  - Pattern is a Galois LFSR: next = (d >> 1) ^ (d[0] ? TAPS : 0).
  - A seed of 0 is replaced by 1 at latch time, because the all-zero state locks up.
  - out_data carries the LFSR state.
- Undefined:
  - Incrementing pattern.
  - TAPS is unused.
  - Seed 0 is legal and emitted as 0.
- Handshake, FSM and timing are identical in both builds.

## Test plan
- Reset: assert rst asynchronously mid-RUN with out_valid=1 → all outputs are 0 before the next clk edge. No done follows, and state is IDLE after release.
- Increment and wrap: seed=0xFE, len=4, out_ready=1 → words FE, FF, 00, 01 on 4 consecutive cycles. done pulses for 1 cycle after the last word. count=4.
- Backpressure: seed=0x10, len=3, out_ready low for cycles 2-4 → 0x11 is held with valid high for 3 cycles. The sequence then continues 0x11, 0x12, and count ends at 3.
- Zero length: len=0, start=1 → out_valid stays 0, done high for the one cycle after the start edge, count=0.
- LFSR build, STIM_GEN_LFSR_EN defined: seed=0x01, len=3 → words 0x01, 0xB8, 0x5C. With seed=0x00, the first word is 0x01.
- Start during RUN: pulse start with len=9 while a len=2 sequence runs → exactly 2 words, count=2. The new len is not used.

Source files
------------

// File: rtl/stim_gen.sv
// stim_gen: on start, emits len words over valid/ready and then pulses done.
// Pattern is an incrementing count; define STIM_GEN_LFSR_EN for a Galois LFSR.
module stim_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  parameter logic [WIDTH-1:0] TAPS = 'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, nxt, seed_eff;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d;
  logic valid_q, busy_q, done_q, hs, go, load;
  assign hs = valid_q & out_ready;
  assign go = (state_q == IDLE) & start;
  assign load = go & (len != '0);
`ifdef STIM_GEN_LFSR_EN
  // all-zero is the LFSR lock-up state, so a zero seed is promoted to 1
  assign nxt = (data_q >> 1) ^ (data_q[0] ? TAPS : '0);
  assign seed_eff = (seed == '0) ? WIDTH'(1) : seed;
`else
  assign nxt = data_q + WIDTH'(1);
  assign seed_eff = seed;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (len != '0) ? RUN : DONE;
      RUN:  if (hs && (count_q + LEN_W'(1) == len_q)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    len_d = load ? len : len_q;
    data_d = load ? seed_eff : hs ? nxt : data_q;
    count_d = go ? '0 : hs ? count_q + LEN_W'(1) : count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q <= '0;
      len_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      len_q <= len_d;
      count_q <= count_d;
      valid_q <= state_d == RUN;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
    end
  assign out_data = data_q;
  assign out_valid = valid_q;
  assign busy = busy_q;
  assign done = done_q;
  assign count = count_q;
endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: scoreboard bench for stim_gen; expected words are queued at start
// and popped on every observed handshake.
module tb_stim_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [7:0] len = '0, seed = '0, out_data, count;
  logic out_valid, busy, done;
  logic [7:0] sb_q[$];
  int n_cmp = 0, n_err = 0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data, prev_count;

  stim_gen dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .seed(seed),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] d);
`ifdef STIM_GEN_LFSR_EN
    return (d >> 1) ^ (d[0] ? 8'hB8 : 8'h00);
`else
    return d + 8'd1;
`endif
  endfunction

  function automatic logic [7:0] first(input logic [7:0] s);
`ifdef STIM_GEN_LFSR_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_count", count, prev_count);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("extra_word", out_data, 32'hFFFF_FFFF);
        else chk("word", out_data, sb_q.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_count = count;
    end
  end

  // bp bit k low-drives out_ready during RUN cycle k; noisy keeps start high with len=9
  task automatic run_seq(input logic [7:0] s, input logic [7:0] l, input logic [15:0] bp, input bit noisy);
    logic [7:0] w;
    int k;
    w = first(s);
    for (int i = 0; i < l; i++) begin
      sb_q.push_back(w);
      w = nxt(w);
    end
    start = 1'b1;
    len = l;
    seed = s;
    out_ready = !bp[0];
    @(posedge clk); #1;
    start = noisy;
    len = noisy ? 8'd9 : 8'd0;
    seed = 8'h55;
    if (l != 0) chk("first_valid", out_valid, 1);
    k = 0;
    while (!done && k < 200) begin
      out_ready = !bp[k[3:0]];
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("done_timeout", k < 200, 1);
    chk("cycles", k, l + ((l != 0) ? $countones(bp) : 0));
    chk("done_hi", done, 1);
    chk("busy_done", busy, 1);
    chk("valid_done", out_valid, 0);
    chk("count_end", count, l);
    chk("sb_empty", sb_q.size(), 0);
    if (l != 0) chk("data_end", out_data, w);
    @(posedge clk); #1;
    chk("done_lo", done, 0);
    chk("busy_idle", busy, 0);
    chk("count_hold", count, l);
    out_ready = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // abort a long sequence mid-RUN
    for (int i = 0; i < 20; i++) sb_q.push_back(8'h30 + 8'(i));
    start = 1'b1; len = 8'd20; seed = 8'h30; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_abort_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("abort_data", out_data, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", count, 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_abort_done", done, 0);
      chk("post_abort_busy", busy, 0);
    end
    out_ready = 1'b0;
    run_seq(8'hFE, 8'd4, 16'h0000, 1'b0);
    run_seq(8'h10, 8'd3, 16'b1110, 1'b0);
    run_seq(8'h00, 8'd0, 16'h0000, 1'b0);
    chk("zero_len_count", count, 0);
    run_seq(8'h40, 8'd2, 16'h0000, 1'b1);
    run_seq(8'h01, 8'd3, 16'h0000, 1'b0);
    run_seq(8'h00, 8'd1, 16'h0000, 1'b0);
    run_seq(8'hA5, 8'd5, 16'b0101, 1'b0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
